// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads two bytes per instruction from byte-wide
// memory and streams them into the instruction register (low byte first).
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    TIMEOUT    = 15
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  PCLoad,
    input  logic [ADDR_WIDTH-1:0] PCLoadValue,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic                  MemRead,
    input  logic                  MemReady,
    input  logic [7:0]            MemData,
    output logic [7:0]            IRData,
    output logic                  IRWrite,
    output logic                  IRLH,
    output logic                  InstrValid,
    input  logic                  InstrAccept,
    output logic [ADDR_WIDTH-1:0] PCOut,
    output logic                  FetchErr
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH_LO,
        FETCH_HI,
        VALID
    } state_t;

    // The timeout fires on the cycle that would be the TIMEOUT-th consecutive wait.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [7:0]            wait_cnt;
    logic [7:0]            next_wait_cnt;
    logic                  fetch_err;
    logic                  next_fetch_err;
    logic                  fetching;
    logic                  ir_write;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            wait_cnt  <= 8'd0;
            fetch_err <= 1'b0;
        end else begin
            state     <= next_state;
            pc        <= next_pc;
            wait_cnt  <= next_wait_cnt;
            fetch_err <= next_fetch_err;
        end
    end

    // PCLoad overrides everything, including a byte arriving in the same cycle.
    always_comb begin
        next_state     = state;
        next_pc        = pc;
        next_wait_cnt  = wait_cnt;
        next_fetch_err = fetch_err;
        ir_write       = 1'b0;
        fetching       = (state == FETCH_LO) || (state == FETCH_HI);

        if (PCLoad) begin
            next_pc        = PCLoadValue;
            next_fetch_err = 1'b0;
            next_wait_cnt  = 8'd0;
            next_state     = Enable ? FETCH_LO : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (Enable && !fetch_err) begin
                        next_state    = FETCH_LO;
                        next_wait_cnt = 8'd0;
                    end
                end
                FETCH_LO, FETCH_HI: begin
                    if (MemReady) begin
                        ir_write      = 1'b1;
                        next_pc       = pc + 1'b1;
                        next_wait_cnt = 8'd0;
                        next_state    = (state == FETCH_LO) ? FETCH_HI : VALID;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        next_fetch_err = 1'b1;
                        next_wait_cnt  = 8'd0;
                        next_state     = IDLE;
                    end else begin
                        next_wait_cnt = wait_cnt + 8'd1;
                    end
                end
                VALID: begin
                    if (InstrAccept) begin
                        next_wait_cnt = 8'd0;
                        next_state    = Enable ? FETCH_LO : IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign MemAddr    = pc;
    assign PCOut      = pc;
    assign MemRead    = fetching;
    assign IRData     = MemData;
    assign IRWrite    = ir_write;
    assign IRLH       = (state == FETCH_HI);
    assign InstrValid = (state == VALID);
    assign FetchErr   = fetch_err;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and randomized bench for instruction_fetch_unit, checked against a
// transaction-level model (busy flag + byte count) of the fetch behaviour.
module tb_instruction_fetch_unit;

    localparam int TIMEOUT = 15;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Enable;
    logic        PCLoad;
    logic [15:0] PCLoadValue;
    logic [15:0] MemAddr;
    logic        MemRead;
    logic        MemReady;
    logic [7:0]  MemData;
    logic [7:0]  IRData;
    logic        IRWrite;
    logic        IRLH;
    logic        InstrValid;
    logic        InstrAccept;
    logic [15:0] PCOut;
    logic        FetchErr;

    logic [7:0]  junk;

    int checks   = 0;
    int failures = 0;
    string phase = "init";

    // Model: is an instruction in progress, how many bytes it already has.
    logic [15:0] m_pc;
    logic [15:0] m_ipc;
    bit          m_busy;
    bit          m_err;
    int          m_got;
    int          m_waits;

    logic [7:0]  ir_lo;
    logic [7:0]  ir_hi;

    always #5 Clock = ~Clock;

    instruction_fetch_unit #(
        .ADDR_WIDTH (16),
        .RESET_PC   (16'h0000),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Enable      (Enable),
        .PCLoad      (PCLoad),
        .PCLoadValue (PCLoadValue),
        .MemAddr     (MemAddr),
        .MemRead     (MemRead),
        .MemReady    (MemReady),
        .MemData     (MemData),
        .IRData      (IRData),
        .IRWrite     (IRWrite),
        .IRLH        (IRLH),
        .InstrValid  (InstrValid),
        .InstrAccept (InstrAccept),
        .PCOut       (PCOut),
        .FetchErr    (FetchErr)
    );

    function automatic logic [7:0] byte_at(input logic [15:0] a);
        if (a == 16'h0000) return 8'h34;
        if (a == 16'h0001) return 8'h12;
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    assign MemData = MemReady ? byte_at(MemAddr) : junk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_pc    = 16'h0000;
        m_ipc   = 16'h0000;
        m_busy  = 1'b0;
        m_err   = 1'b0;
        m_got   = 0;
        m_waits = 0;
    endtask

    task automatic model_edge();
        if (!Reset) begin
            model_reset();
        end else if (PCLoad) begin
            m_pc    = PCLoadValue;
            m_err   = 1'b0;
            m_busy  = Enable;
            m_got   = 0;
            m_waits = 0;
        end else if (!m_busy) begin
            if (Enable && !m_err) begin
                m_busy  = 1'b1;
                m_got   = 0;
                m_waits = 0;
            end
        end else if (m_got < 2) begin
            if (MemReady) begin
                if (m_got == 0) m_ipc = m_pc;
                m_pc    = m_pc + 16'd1;
                m_got   = m_got + 1;
                m_waits = 0;
            end else begin
                m_waits = m_waits + 1;
                if (m_waits == TIMEOUT) begin
                    m_err  = 1'b1;
                    m_busy = 1'b0;
                    m_got  = 0;
                end
            end
        end else if (InstrAccept) begin
            m_busy = Enable;
            m_got  = 0;
        end
    endtask

    // One clock: compare all outputs mid-cycle, then advance the model on the edge.
    task automatic step();
        logic exp_read;
        logic exp_valid;
        logic exp_lh;
        logic exp_wr;
        logic [7:0] exp_data;
        @(negedge Clock);
        exp_read  = m_busy && (m_got < 2);
        exp_valid = m_busy && (m_got == 2);
        exp_lh    = m_busy && (m_got == 1);
        exp_wr    = exp_read && MemReady && !PCLoad && Reset;
        exp_data  = MemReady ? byte_at(m_pc) : junk;
        chk("MemRead",    MemRead,    exp_read);
        chk("InstrValid", InstrValid, exp_valid);
        chk("IRLH",       IRLH,       exp_lh);
        chk("IRWrite",    IRWrite,    exp_wr);
        chk("MemAddr",    MemAddr,    m_pc);
        chk("PCOut",      PCOut,      m_pc);
        chk("FetchErr",   FetchErr,   m_err);
        chk("IRData",     IRData,     exp_data);
        if (exp_valid)
            chk("instr", {ir_hi, ir_lo}, {byte_at(m_ipc + 16'd1), byte_at(m_ipc)});
        if (IRWrite) begin
            if (IRLH) ir_hi = IRData;
            else      ir_lo = IRData;
        end
        @(posedge Clock);
        model_edge();
        #1;
        junk = 8'($urandom);
    endtask

    initial begin
        Reset       = 1'b0;
        Enable      = 1'b0;
        PCLoad      = 1'b0;
        PCLoadValue = 16'h0000;
        MemReady    = 1'b0;
        InstrAccept = 1'b0;
        junk        = 8'h5C;
        ir_lo       = 8'h00;
        ir_hi       = 8'h00;
        model_reset();

        phase = "reset";
        #2;
        chk("rst_MemRead", MemRead, 1'b0);
        chk("rst_PCOut", PCOut, 16'h0000);
        chk("rst_Valid", InstrValid, 1'b0);
        step();
        step();
        Reset = 1'b1;
        step();
        step();

        phase = "t1_basic";
        Enable   = 1'b1;
        MemReady = 1'b1;
        repeat (4) step();
        chk("t1_instr", {ir_hi, ir_lo}, 16'h1234);
        chk("t1_pc", PCOut, 16'h0002);
        chk("t1_valid", InstrValid, 1'b1);

        phase = "t2_slow";
        MemReady    = 1'b0;
        InstrAccept = 1'b1;
        step();
        InstrAccept = 1'b0;
        for (int b = 0; b < 2; b++) begin
            MemReady = 1'b0;
            repeat (3) step();
            MemReady = 1'b1;
            step();
        end
        MemReady = 1'b0;
        repeat (5) step();
        chk("t2_valid_held", InstrValid, 1'b1);
        chk("t2_pc", PCOut, 16'h0004);
        InstrAccept = 1'b1;
        step();
        InstrAccept = 1'b0;
        chk("t2_restart_read", MemRead, 1'b1);
        chk("t2_restart_addr", MemAddr, 16'h0004);

        phase = "t3_load";
        MemReady = 1'b1;
        step();
        chk("t3_in_hi", IRLH, 1'b1);
        PCLoad      = 1'b1;
        PCLoadValue = 16'hFFFF;
        step();
        PCLoad = 1'b0;
        chk("t3_addr_ffff", MemAddr, 16'hFFFF);
        step();
        chk("t3_addr_wrap", MemAddr, 16'h0000);
        step();
        chk("t3_valid", InstrValid, 1'b1);
        chk("t3_pc", PCOut, 16'h0001);
        chk("t3_instr", {ir_hi, ir_lo}, 16'h34A5);

        phase = "t4_timeout";
        MemReady    = 1'b0;
        InstrAccept = 1'b1;
        step();
        InstrAccept = 1'b0;
        repeat (TIMEOUT - 1) step();
        chk("t4_no_err_yet", FetchErr, 1'b0);
        step();
        chk("t4_err", FetchErr, 1'b1);
        chk("t4_idle", MemRead, 1'b0);
        chk("t4_pc_kept", PCOut, 16'h0001);
        repeat (3) step();
        PCLoad      = 1'b1;
        PCLoadValue = 16'h0100;
        step();
        PCLoad = 1'b0;
        chk("t4_err_clr", FetchErr, 1'b0);
        chk("t4_restart", MemAddr, 16'h0100);
        MemReady = 1'b1;

        phase = "t5_async";
        step();
        chk("t5_in_hi", IRLH, 1'b1);
        #2;
        Reset = 1'b0;
        #1;
        chk("t5_read", MemRead, 1'b0);
        chk("t5_lh", IRLH, 1'b0);
        chk("t5_wr", IRWrite, 1'b0);
        chk("t5_pc", PCOut, 16'h0000);
        model_reset();
        step();
        Reset = 1'b1;
        step();
        chk("t5_lo", IRLH, 1'b0);
        chk("t5_addr", MemAddr, 16'h0000);
        repeat (3) step();
        chk("t5_instr", {ir_hi, ir_lo}, 16'h1234);

        phase = "t6_disable";
        InstrAccept = 1'b1;
        step();
        InstrAccept = 1'b0;
        Enable      = 1'b0;
        MemReady    = 1'b0;
        repeat (2) step();
        MemReady = 1'b1;
        repeat (2) step();
        chk("t6_valid", InstrValid, 1'b1);
        InstrAccept = 1'b1;
        step();
        InstrAccept = 1'b0;
        repeat (3) step();
        chk("t6_idle", MemRead, 1'b0);
        chk("t6_pc", PCOut, 16'h0004);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            Enable      = ($urandom_range(0, 9) != 0);
            PCLoad      = ($urandom_range(0, 19) == 0);
            PCLoadValue = 16'($urandom);
            MemReady    = ($urandom_range(0, 2) != 0);
            InstrAccept = ($urandom_range(0, 1) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
